// File: rtl/host_cmd_queue_if.sv
// host_cmd_queue_if -- host register bus plus command channel of host_cmd_queue.
//
// Signals:
//   reg_wr_en / reg_wr_addr[2:0] / reg_wr_data[31:0] : host register write
//   reg_rd_en / reg_rd_addr[2:0]                     : host register read request
//   reg_rd_data[31:0] / reg_rd_valid                 : read response, one cycle after the request
//   cmd_valid / cmd_data[63:0] / cmd_ready           : command channel towards the control unit
//
// Modports:
//   slave  : the queue (consumes register traffic, produces commands)
//   master : the environment (host plus command consumer)
//
// Command handshake: a transfer happens on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_valid never depends on cmd_ready, and while
// cmd_valid=1 and cmd_ready=0 the producer holds cmd_data unchanged.
interface host_cmd_queue_if;
  logic        reg_wr_en;
  logic [2:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic        reg_rd_en;
  logic [2:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic        reg_rd_valid;
  logic        cmd_valid;
  logic [63:0] cmd_data;
  logic        cmd_ready;

  modport slave (
    input  reg_wr_en, reg_wr_addr, reg_wr_data,
    input  reg_rd_en, reg_rd_addr,
    output reg_rd_data, reg_rd_valid,
    output cmd_valid, cmd_data,
    input  cmd_ready
  );

  modport master (
    output reg_wr_en, reg_wr_addr, reg_wr_data,
    output reg_rd_en, reg_rd_addr,
    input  reg_rd_data, reg_rd_valid,
    input  cmd_valid, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/host_cmd_queue.sv
// host_cmd_queue -- host-facing command queue for the systolic array control unit.
//
// The host assembles 64-bit commands through two register writes (CMD_LO then
// CMD_HI). Each completed command enters a first-word-fall-through FIFO whose
// head is offered on the command channel. The block also tracks commands
// handed to the control unit but not yet finished (outstanding), counts
// completions, and raises a level interrupt from sticky W1C status bits.
//
// Register map (word addresses):
//   0 CMD_LO (WO)  1 CMD_HI (WO)  2 STATUS (RO)  3 IRQ_STATUS (W1C)
//   4 IRQ_ENABLE (RW, [2:0])  5 DONE_COUNT (RO)  6/7 unmapped
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   bus           : host_cmd_queue_if.slave (register bus + command channel)
//   cu_busy       : control unit busy level (reported in STATUS[10])
//   cu_done_irq   : one-cycle pulse per completed task
//   irq           : level interrupt to host
//
// Optional feature: define HOST_CMD_QUEUE_CHECK_EN to reject commands whose
// M, K or N is 0 or larger than SYSTOLIC_ARRAY_WIDTH (sets IRQ_STATUS[2]).
module host_cmd_queue #(
  parameter int FIFO_DEPTH           = 4,
  parameter int SYSTOLIC_ARRAY_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  host_cmd_queue_if.slave    bus,
  input  logic               cu_busy,
  input  logic               cu_done_irq,
  output logic               irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [63:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   staging_q, staging_d;
  logic [7:0]    outstanding_q, outstanding_d;
  logic [15:0]   done_count_q, done_count_d;
  logic [2:0]    irq_status_q, irq_status_d;
  logic [2:0]    irq_enable_q, irq_enable_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic          empty, full, pop, push, hi_wr, cmd_err, overflow;
  logic [63:0]   cmd_word;
  logic [2:0]    irq_set, irq_clr;
  logic [31:0]   status_word;

`ifdef HOST_CMD_QUEUE_CHECK_EN
  function automatic logic dim_ok(input logic [7:0] d);
    return (d != 8'd0) && (int'(d) <= SYSTOLIC_ARRAY_WIDTH);
  endfunction
`endif

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_C);
    pop      = !empty && bus.cmd_ready;
    cmd_word = {bus.reg_wr_data, staging_q};
    hi_wr    = bus.reg_wr_en && (bus.reg_wr_addr == 3'd1);
    cmd_err  = 1'b0;
`ifdef HOST_CMD_QUEUE_CHECK_EN
    // Legality is judged before fullness: an illegal command reports cmd_err only.
    cmd_err  = hi_wr && !(dim_ok(cmd_word[7:0]) && dim_ok(cmd_word[15:8]) &&
                          dim_ok(cmd_word[23:16]));
`endif
    // Fullness is judged on the pre-edge count, so a same-cycle pop never frees a slot.
    push     = hi_wr && !cmd_err && !full;
    overflow = hi_wr && !cmd_err && full;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = cmd_word;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    staging_d = staging_q;
    if (bus.reg_wr_en && (bus.reg_wr_addr == 3'd0)) staging_d = bus.reg_wr_data;

    // A handshake and a completion in the same cycle cancel out.
    outstanding_d = outstanding_q;
    if (pop && !cu_done_irq && (outstanding_q != 8'hFF))
      outstanding_d = outstanding_q + 8'd1;
    else if (cu_done_irq && !pop && (outstanding_q != 8'd0))
      outstanding_d = outstanding_q - 8'd1;

    done_count_d = cu_done_irq ? done_count_q + 16'd1 : done_count_q;

    // Set beats clear so an event arriving during a W1C is never lost.
    irq_set      = {cmd_err, overflow, cu_done_irq};
    irq_clr      = (bus.reg_wr_en && (bus.reg_wr_addr == 3'd3)) ? bus.reg_wr_data[2:0] : 3'b000;
    irq_status_d = (irq_status_q & ~irq_clr) | irq_set;

    irq_enable_d = irq_enable_q;
    if (bus.reg_wr_en && (bus.reg_wr_addr == 3'd4)) irq_enable_d = bus.reg_wr_data[2:0];

    status_word = {8'h00, outstanding_q, 5'b00000, cu_busy, empty, full, 8'(count_q)};
    rd_valid_d  = bus.reg_rd_en;
    rd_data_d   = 32'h0;
    if (bus.reg_rd_en) begin
      case (bus.reg_rd_addr)
        3'd2:    rd_data_d = status_word;
        3'd3:    rd_data_d = {29'h0, irq_status_q};
        3'd4:    rd_data_d = {29'h0, irq_enable_q};
        3'd5:    rd_data_d = {16'h0, done_count_q};
        default: rd_data_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      staging_q     <= '0;
      outstanding_q <= '0;
      done_count_q  <= '0;
      irq_status_q  <= '0;
      irq_enable_q  <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      staging_q     <= staging_d;
      outstanding_q <= outstanding_d;
      done_count_q  <= done_count_d;
      irq_status_q  <= irq_status_d;
      irq_enable_q  <= irq_enable_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  // Stale entries never leak out: cmd_data reads 0 whenever the FIFO is empty.
  assign bus.cmd_valid    = !empty;
  assign bus.cmd_data     = empty ? 64'h0 : mem_q[rd_ptr_q];
  assign bus.reg_rd_data  = rd_data_q;
  assign bus.reg_rd_valid = rd_valid_q;
  assign irq              = |(irq_status_q & irq_enable_q);

endmodule

// File: tb/tb_host_cmd_queue.sv
// tb_host_cmd_queue -- directed scenarios followed by a randomized run, all
// checked against a queue-based reference model of the command queue.
module tb_host_cmd_queue;
  localparam int DEPTH = 4;
  localparam int W     = 16;

  logic clk = 1'b0;
  logic rst;
  logic cu_busy, cu_done_irq, irq;

  host_cmd_queue_if bus();

  host_cmd_queue #(.FIFO_DEPTH(DEPTH), .SYSTOLIC_ARRAY_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cu_busy(cu_busy), .cu_done_irq(cu_done_irq), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] exp_q[$];
  int          m_out;
  logic [15:0] m_done;
  logic [2:0]  m_irqs, m_irqen;
  logic [31:0] m_stage;
  logic        m_rdv;
  logic [31:0] m_rdd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic dims_legal(input logic [63:0] c);
    int m, k, n;
    m = int'(c[7:0]); k = int'(c[15:8]); n = int'(c[23:16]);
    return (m >= 1 && m <= W) && (k >= 1 && k <= W) && (n >= 1 && n <= W);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_out = 0; m_done = 16'h0; m_irqs = 3'b0; m_irqen = 3'b0;
    m_stage = 32'h0; m_rdv = 1'b0; m_rdd = 32'h0;
  endtask

  task automatic drive_idle();
    bus.reg_wr_en = 1'b0; bus.reg_wr_addr = 3'd0; bus.reg_wr_data = 32'h0;
    bus.reg_rd_en = 1'b0; bus.reg_rd_addr = 3'd0; bus.cmd_ready = 1'b0;
    cu_busy = 1'b0; cu_done_irq = 1'b0;
  endtask

  // One clock: inputs were set at the preceding falling edge; the model is
  // advanced from its pre-edge state and outputs are compared at the next
  // falling edge.
  task automatic tick();
    logic        pop, done, push;
    logic [63:0] cmd;
    logic [2:0]  set, clr;
    int          size;
    @(posedge clk);
    size = exp_q.size();
    pop  = (size != 0) && bus.cmd_ready;
    done = cu_done_irq;
    push = 1'b0; set = 3'b0; clr = 3'b0; cmd = 64'h0;
    m_rdv = bus.reg_rd_en;
    m_rdd = 32'h0;
    if (bus.reg_rd_en) begin
      case (bus.reg_rd_addr)
        3'd2: m_rdd = {8'h0, 8'(m_out), 5'b0, cu_busy, (size == 0), (size == DEPTH), 8'(size)};
        3'd3: m_rdd = {29'h0, m_irqs};
        3'd4: m_rdd = {29'h0, m_irqen};
        3'd5: m_rdd = {16'h0, m_done};
        default: m_rdd = 32'h0;
      endcase
    end
    if (bus.reg_wr_en) begin
      case (bus.reg_wr_addr)
        3'd0: m_stage = bus.reg_wr_data;
        3'd1: begin
          cmd = {bus.reg_wr_data, m_stage};
`ifdef HOST_CMD_QUEUE_CHECK_EN
          if (!dims_legal(cmd)) set[2] = 1'b1;
          else
`endif
          if (size == DEPTH) set[1] = 1'b1;
          else push = 1'b1;
        end
        3'd3: clr = bus.reg_wr_data[2:0];
        3'd4: m_irqen = bus.reg_wr_data[2:0];
        default: ;
      endcase
    end
    if (done) begin
      set[0] = 1'b1;
      m_done = m_done + 16'd1;
    end
    if (pop && !done) m_out = (m_out == 255) ? 255 : m_out + 1;
    else if (done && !pop && m_out > 0) m_out = m_out - 1;
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back(cmd);
    m_irqs = (m_irqs & ~clr) | set;
    @(negedge clk);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_cmd_valid"}, bus.cmd_valid, exp_q.size() != 0);
    chk({tag, "_cmd_data"}, bus.cmd_data, (exp_q.size() != 0) ? exp_q[0] : 64'h0);
    chk({tag, "_irq"}, irq, |(m_irqs & m_irqen));
    chk({tag, "_rd_valid"}, bus.reg_rd_valid, m_rdv);
    if (m_rdv) chk({tag, "_rd_data"}, bus.reg_rd_data, m_rdd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.reg_wr_en = 1'b1; bus.reg_wr_addr = a; bus.reg_wr_data = d;
    tick();
    bus.reg_wr_en = 1'b0;
    check_outputs("wr");
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    bus.reg_rd_en = 1'b1; bus.reg_rd_addr = a;
    tick();
    bus.reg_rd_en = 1'b0;
    check_outputs("rd");
    chk(tag, bus.reg_rd_data, exp);
  endtask

  task automatic push_cmd(input logic [31:0] lo, input logic [31:0] hi);
    wr(3'd0, lo);
    wr(3'd1, hi);
  endtask

  // Reset asserted just after a falling edge; its effect must be visible
  // before any further clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive_idle();
    #1;
    chk({tag, "_rst_cmd_valid"}, bus.cmd_valid, 1'b0);
    chk({tag, "_rst_cmd_data"}, bus.cmd_data, 64'h0);
    chk({tag, "_rst_irq"}, irq, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_rst_rd_valid"}, bus.reg_rd_valid, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_cmd_valid", bus.cmd_valid, 1'b0);
    chk("reset_cmd_data", bus.cmd_data, 64'h0);
    chk("reset_rd_valid", bus.reg_rd_valid, 1'b0);
    chk("reset_rd_data", bus.reg_rd_data, 32'h0);
    chk("reset_irq", irq, 1'b0);
    rst = 1'b0;
    rd(3'd2, 32'h0000_0200, "reset_status");
    rd(3'd5, 32'h0, "reset_done_count");
    rd(3'd4, 32'h0, "reset_irq_enable");

    // Single command, consumer stalled
    push_cmd(32'h1010_1010, 32'h4B23_2019);
    chk("single_cmd_valid", bus.cmd_valid, 1'b1);
    chk("single_cmd_data", bus.cmd_data, 64'h4B23_2019_1010_1010);
    rd(3'd2, 32'h0000_0001, "single_status");
    rd(3'd0, 32'h0, "wo_cmd_lo_reads_zero");
    rd(3'd7, 32'h0, "unmapped_reads_zero");

    // Overflow: five pushes into four entries
    do_reset("ovf");
    for (int i = 0; i < 5; i++) push_cmd(32'h0101_0100 + 32'(i + 1), 32'(i));
    rd(3'd2, 32'h0000_0104, "ovf_status_full");
    rd(3'd3, 32'h0000_0002, "ovf_irq_status");
    chk("ovf_head_is_first", bus.cmd_data, 64'h0000_0000_0101_0101);
    wr(3'd3, 32'h2);
    rd(3'd3, 32'h0, "ovf_w1c_cleared");

    // Two pops on consecutive edges, then two completions
    do_reset("pop");
    push_cmd(32'h0203_0405, 32'h1111_2222);
    push_cmd(32'h0304_0506, 32'h3333_4444);
    bus.cmd_ready = 1'b1;
    tick(); check_outputs("pop1");
    chk("pop1_next_head", bus.cmd_data, 64'h3333_4444_0304_0506);
    tick(); check_outputs("pop2");
    bus.cmd_ready = 1'b0;
    rd(3'd2, 32'h0002_0200, "pop_outstanding2");
    cu_done_irq = 1'b1;
    tick(); check_outputs("done1");
    tick(); check_outputs("done2");
    cu_done_irq = 1'b0;
    rd(3'd2, 32'h0000_0200, "done_outstanding0");
    rd(3'd5, 32'h0000_0002, "done_count2");
    rd(3'd3, 32'h0000_0001, "done_irq_status");
    chk("done_irq_masked", irq, 1'b0);
    wr(3'd4, 32'h1);
    chk("done_irq_enabled", irq, 1'b1);
    wr(3'd3, 32'h1);
    chk("done_irq_cleared", irq, 1'b0);

    // Handshake and completion together; completion with nothing outstanding
    do_reset("sim");
    push_cmd(32'h0101_0101, 32'h0);
    push_cmd(32'h0202_0202, 32'h0);
    bus.cmd_ready = 1'b1;
    tick(); check_outputs("sim_pop");
    cu_done_irq = 1'b1;
    tick(); check_outputs("sim_both");
    bus.cmd_ready = 1'b0;
    cu_done_irq = 1'b0;
    rd(3'd2, 32'h0001_0200, "sim_outstanding_unchanged");
    cu_done_irq = 1'b1;
    tick(); check_outputs("sim_done_a");
    tick(); check_outputs("sim_done_b");
    cu_done_irq = 1'b0;
    rd(3'd2, 32'h0000_0200, "sim_outstanding_floor");
    rd(3'd5, 32'h0000_0003, "sim_done_count");

    // Command with K=0
    do_reset("kzero");
    push_cmd(32'h0010_0010, 32'h0);
`ifdef HOST_CMD_QUEUE_CHECK_EN
    rd(3'd2, 32'h0000_0200, "kzero_not_pushed");
    rd(3'd3, 32'h0000_0004, "kzero_cmd_err");
`else
    rd(3'd2, 32'h0000_0001, "kzero_pushed");
    rd(3'd3, 32'h0000_0000, "kzero_no_err");
`endif

    // Reset with three queued commands
    do_reset("rq");
    for (int i = 0; i < 3; i++) push_cmd(32'h0404_0404, 32'(i));
    rd(3'd2, 32'h0000_0003, "rq_three_queued");
    bus.cmd_ready = 1'b1;
    do_reset("rq_mid");
    rd(3'd2, 32'h0000_0200, "rq_empty_after_reset");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      bus.reg_wr_en = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: bus.reg_wr_addr = 3'd0;
        3, 4, 5: bus.reg_wr_addr = 3'd1;
        default: bus.reg_wr_addr = 3'(r - 4);
      endcase
      if (bus.reg_wr_addr == 3'd0)
        bus.reg_wr_data = {8'($urandom), 8'($urandom_range(0, W + 2)),
                           8'($urandom_range(0, W + 2)), 8'($urandom_range(0, W + 2))};
      else
        bus.reg_wr_data = $urandom;
      bus.cmd_ready = ($urandom_range(0, 2) == 0);
      cu_done_irq   = ($urandom_range(0, 3) == 0);
      cu_busy       = 1'($urandom_range(0, 1));
      bus.reg_rd_en = 1'($urandom_range(0, 1));
      bus.reg_rd_addr = 3'($urandom_range(0, 7));
      tick();
      check_outputs("rnd");
    end
    drive_idle();
    tick();
    check_outputs("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
